// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and address split helpers for the
// direct-mapped cache controller.
package cache_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int INDEX_WIDTH = 7;
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
  localparam int CACHE_LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOOKUP   = 2'd1,
    ST_MEM_REQ  = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  // Upper address bits identify which memory word occupies a line.
  function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:INDEX_WIDTH];
  endfunction

  // Lower address bits select the line.
  function automatic logic [INDEX_WIDTH-1:0] index_of(input logic [ADDR_WIDTH-1:0] addr);
    return addr[INDEX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/cache_valid_bits.sv
// Per-line valid flags: cleared by reset or flush, set one line at a time on
// refill, read combinationally at the current lookup index.
module cache_valid_bits #(
  parameter int LINES = 128,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             set_en,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid
);

  logic [LINES-1:0] valid_reg;

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    // One flag per line; flush clear wins over a set in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (clear) begin
        valid_reg[gi] <= 1'b0;
      end else if (set_en && (set_idx == IDX_W'(gi))) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  assign rd_valid = valid_reg[rd_idx];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, one-word-per-line cache controller with write-through stores
// (no write-allocate) and single-word refill on load misses.
module dm_cache_ctrl
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   cpu_req_valid,
  output logic                   cpu_req_ready,
  input  logic                   cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_req_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_req_wdata,
  output logic                   cpu_resp_valid,
  output logic [DATA_WIDTH-1:0]  cpu_resp_rdata,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_we,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  input  logic                   mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_resp_rdata,
  output logic [INDEX_WIDTH-1:0] ram_index,
  output logic                   tag_we,
  output logic [TAG_WIDTH-1:0]   tag_wdata,
  input  logic [TAG_WIDTH-1:0]   tag_rdata,
  output logic                   data_we,
  output logic [DATA_WIDTH-1:0]  data_wdata,
  input  logic [DATA_WIDTH-1:0]  data_rdata
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic line_valid;
  logic hit;
  logic in_idle;
  logic refill;

  assign in_idle       = (state == ST_IDLE);
  assign cpu_req_ready = in_idle && !flush;

  // In IDLE the RAMs are addressed straight from the CPU port so their
  // registered read data is ready exactly when LOOKUP evaluates the hit.
  assign ram_index = in_idle ? index_of(cpu_req_addr) : index_of(addr_reg);
  assign hit       = line_valid && (tag_rdata == tag_of(addr_reg));
  assign refill    = (state == ST_MEM_WAIT) && mem_resp_valid && !we_reg;

  cache_valid_bits #(
    .LINES (CACHE_LINES),
    .IDX_W (INDEX_WIDTH)
  ) u_valid (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_idle && flush),
    .set_en   (refill),
    .set_idx  (index_of(addr_reg)),
    .rd_idx   (index_of(addr_reg)),
    .rd_valid (line_valid)
  );

  // Controller sequencing and request latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            addr_reg  <= cpu_req_addr;
            we_reg    <= cpu_req_we;
            wdata_reg <= cpu_req_wdata;
            state     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP:   state <= (hit && !we_reg) ? ST_IDLE : ST_MEM_REQ;
        ST_MEM_REQ:  if (mem_req_ready) state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (mem_resp_valid) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: responses, RAM writes and the memory request all follow
  // from the current state and the latched request.
  always_comb begin
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    tag_we         = 1'b0;
    data_we        = 1'b0;
    data_wdata     = '0;
    mem_req_valid  = (state == ST_MEM_REQ);
    mem_req_we     = we_reg;
    mem_req_addr   = addr_reg;
    mem_req_wdata  = wdata_reg;
    tag_wdata      = tag_of(addr_reg);
    case (state)
      ST_LOOKUP: begin
        if (hit && !we_reg) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_rdata = data_rdata;
        end
        // Store hit keeps the cached copy coherent; memory is written after.
        if (hit && we_reg) begin
          data_we    = 1'b1;
          data_wdata = wdata_reg;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_resp_valid) begin
          cpu_resp_valid = 1'b1;
          if (!we_reg) begin
            cpu_resp_rdata = mem_resp_rdata;
            tag_we         = 1'b1;
            data_we        = 1'b1;
            data_wdata     = mem_resp_rdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: tag/data RAM models, a memory responder with random
// handshake and latency, and a line-level reference model of cache contents.
module tb_dm_cache_ctrl;

  logic        clk, rst, flush;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [6:0]  ram_index;
  logic        tag_we, data_we;
  logic [24:0] tag_wdata, tag_rdata;
  logic [31:0] data_wdata, data_rdata;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .ram_index(ram_index),
    .tag_we(tag_we), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tag and data RAMs with one-cycle registered read.
  logic [24:0] tag_mem  [128];
  logic [31:0] data_mem [128];
  always @(posedge clk) begin
    if (tag_we)  tag_mem[ram_index]  <= tag_wdata;
    if (data_we) data_mem[ram_index] <= data_wdata;
    tag_rdata  <= tag_mem[ram_index];
    data_rdata <= data_mem[ram_index];
  end

  // Default contents of any memory word never written.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  // Memory seen by the DUT (updated only by its write-throughs).
  logic [31:0] bmem [logic [31:0]];
  bit          stall, hold_resp;
  bit          hs_q, q_we, pend, p_we;
  logic [31:0] q_addr, q_wd, p_addr;
  int          wcnt;

  initial begin : mem_model
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    pend = 1'b0;
    wcnt = 0;
    bmem[32'h0000_0085] = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      hs_q   = mem_req_valid && mem_req_ready && !rst;
      q_addr = mem_req_addr;
      q_we   = mem_req_we;
      q_wd   = mem_req_wdata;
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (hs_q) begin
        pend   = 1'b1;
        p_addr = q_addr;
        p_we   = q_we;
        wcnt   = int'($urandom_range(0, 3));
        if (q_we) bmem[q_addr] = q_wd;
      end else if (pend && !hold_resp) begin
        if (wcnt == 0) begin
          mem_resp_valid = 1'b1;
          if (p_we) mem_resp_rdata = $urandom;
          else      mem_resp_rdata = bmem.exists(p_addr) ? bmem[p_addr] : init_val(p_addr);
          pend = 1'b0;
        end else begin
          wcnt--;
        end
      end
      mem_req_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: what each line holds and what memory should contain.
  bit          m_valid [128];
  logic [24:0] m_tag   [128];
  logic [31:0] ref_mem [logic [31:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
  endtask

  // One CPU transaction, checked against the model's prediction.
  task automatic do_txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input int stall_n);
    logic [6:0]  ix;
    logic [24:0] tg;
    bit          exp_hit, got;
    int          exp_hs, exp_twe, exp_dwe, n, lat, hs, twe, dwe, mbad, ibad;
    logic [31:0] exp_data, rd_obs, dw_obs;
    ix = a[6:0];
    tg = a[31:7];
    exp_hit  = m_valid[ix] && (m_tag[ix] == tg);
    exp_data = we ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : init_val(a));
    exp_hs   = (!we && exp_hit) ? 0 : 1;
    exp_twe  = (!we && !exp_hit) ? 1 : 0;
    exp_dwe  = (we == exp_hit) ? 1 : 0;
    if (we) ref_mem[a] = wd;
    else if (!exp_hit) begin m_valid[ix] = 1'b1; m_tag[ix] = tg; end

    if (stall_n > 0) stall = 1'b1;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = a; cpu_req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin n++; @(negedge clk); end
    chk("accept_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0; cpu_req_addr = $urandom; cpu_req_wdata = $urandom; cpu_req_we = $urandom;

    lat = 0; got = 1'b0; hs = 0; twe = 0; dwe = 0; mbad = 0; ibad = 0;
    rd_obs = '0; dw_obs = '0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (tag_we) begin
        twe++;
        if (tag_wdata !== tg || ram_index !== ix) ibad++;
      end
      if (data_we) begin
        dwe++;
        dw_obs = data_wdata;
        if (ram_index !== ix) ibad++;
      end
      if (mem_req_valid) begin
        if (mem_req_addr !== a || mem_req_we !== we || (we && mem_req_wdata !== wd)) mbad++;
        if (mem_req_ready) hs++;
        if (stall_n > 0) begin
          for (int k = 0; k < stall_n; k++) begin
            @(negedge clk);
            lat++;
            chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
            chk("stall_req_addr", mem_req_addr, a);
          end
          stall   = 1'b0;
          stall_n = 0;
        end
      end
      if (cpu_resp_valid) begin got = 1'b1; rd_obs = cpu_resp_rdata; end
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("resp_rdata", rd_obs, exp_data);
    chk("mem_handshakes", 32'(hs), 32'(exp_hs));
    chk("tag_we_count", 32'(twe), 32'(exp_twe));
    chk("data_we_count", 32'(dwe), 32'(exp_dwe));
    chk("mem_req_fields", 32'(mbad), 32'd0);
    chk("ram_write_index_tag", 32'(ibad), 32'd0);
    if (exp_dwe == 1) chk("data_wdata", dw_obs, we ? wd : exp_data);
    if (!we && exp_hit) chk("hit_latency", 32'(lat), 32'd1);
    $display("txn we=%0d addr=%h hit=%0d rdata=%h lat=%0d", we, a, exp_hit, rd_obs, lat);
  endtask

  // Flush in IDLE, optionally racing a CPU request.
  task automatic do_flush(input bit with_req);
    @(posedge clk);
    #1;
    flush = 1'b1;
    if (with_req) begin
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0085;
    end
    @(negedge clk);
    chk("flush_ready_low", 32'(cpu_req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("flush_not_accepted", 32'(cpu_req_ready), 32'd1);
    chk("flush_no_resp", 32'(cpu_resp_valid), 32'd0);
    clear_model();
    $display("flush with_req=%0d", with_req);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int n, viol;
    logic [31:0] a;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; hold_resp = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    clear_model();
    ref_mem[32'h0000_0085] = 32'hDEAD_BEEF;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_resp_rdata", cpu_resp_rdata, 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'd0);
    chk("rst_mem_req_we", 32'(mem_req_we), 32'd0);
    chk("rst_ram_we", 32'({tag_we, data_we}), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("rst_flush_ready", 32'(cpu_req_ready), 32'd0);
    flush = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed sequence.
    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // cold miss, refill DEADBEEF
    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // hit, 1-cycle latency
    do_txn(1'b0, 32'h0000_0105, 32'h0, 0);          // conflict miss
    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // evicted, misses again
    do_txn(1'b0, 32'h0000_0105, 32'h0, 0);          // reinstall 0x105
    do_txn(1'b1, 32'h0000_0105, 32'h1234_5678, 0);  // store hit
    do_txn(1'b0, 32'h0000_0105, 32'h0, 0);          // hit on stored data
    do_txn(1'b1, 32'h2000_0033, 32'hCAFE_F00D, 0);  // store miss, no allocate
    do_txn(1'b0, 32'h2000_0033, 32'h0, 0);          // miss, fetches written data
    do_txn(1'b0, 32'h0000_0777, 32'h0, 5);          // memory stalls 5 cycles

    // Reset while waiting for memory; the response arrives afterwards.
    hold_resp = 1'b1;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0185;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(mem_req_valid && mem_req_ready) && n < 50) begin n++; @(negedge clk); end
    chk("rstmid_req_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    hold_resp = 1'b0;
    viol = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_resp_valid || tag_we || data_we || mem_req_valid) viol++;
    end
    chk("rstmid_quiet", 32'(viol), 32'd0);
    chk("rstmid_idle", 32'(cpu_req_ready), 32'd1);
    clear_model();
    $display("reset during MEM_WAIT, late response ignored");

    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // invalid after reset -> miss
    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // hit
    do_flush(1'b1);
    do_txn(1'b0, 32'h0000_0085, 32'h0, 0);          // invalid after flush -> miss

    // Randomized traffic on a small address pool to mix hits and misses.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) do_flush(1'($urandom_range(0, 1)));
      a = {25'($urandom_range(0, 3)), 7'($urandom_range(0, 7))};
      do_txn(1'($urandom_range(0, 2) == 0), a, $urandom, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, one-word-per-line cache controller. It sits between the CPU load/store port and main memory, and drives the tag RAM and data RAM: index, write enable and write data out, registered read data back. The controller owns the per-line valid bits, the hit compare, the miss refill sequencing and write-through for stores (no write-allocate).

Parameters:
ADDR_WIDTH, 32, byte-free word address width; addr = {tag, index}
DATA_WIDTH, 32, cache word width
INDEX_WIDTH, 7, line index width
TAG_WIDTH, 25, tag width; must equal ADDR_WIDTH-INDEX_WIDTH
CACHE_LINES, 128, line count; must equal 2**INDEX_WIDTH

Ports:
clk  in  1  single clock; all state on posedge
rst  in  1  asynchronous, active-high reset
flush  in  1  level; when sampled high in IDLE, clears all valid bits
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  controller accepts request (IDLE && !flush)
cpu_req_we  in  1  1=store, 0=load
cpu_req_addr  in  ADDR_WIDTH  word address
cpu_req_wdata  in  DATA_WIDTH  store data
cpu_resp_valid  out  1  one-cycle pulse: load data / store done
cpu_resp_rdata  out  DATA_WIDTH  load data; 0 for stores
mem_req_valid  out  1  memory request, held until mem_req_ready
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=write-through, 0=line fetch
mem_req_addr  out  ADDR_WIDTH  latched request address
mem_req_wdata  out  DATA_WIDTH  latched store data
mem_resp_valid  in  1  fetch data / write ack, one-cycle pulse
mem_resp_rdata  in  DATA_WIDTH  fetch data
ram_index  out  INDEX_WIDTH  shared index to tag RAM and data RAM
tag_we  out  1  tag RAM write enable
tag_wdata  out  TAG_WIDTH  tag RAM write data
tag_rdata  in  TAG_WIDTH  tag RAM registered read data (1-cycle latency)
data_we  out  1  data RAM write enable
data_wdata  out  DATA_WIDTH  data RAM write data
data_rdata  in  DATA_WIDTH  data RAM registered read data (1-cycle latency)

Behaviour:
- Reset: state=IDLE, valid[]=0, latched req regs=0. All outputs 0 except cpu_req_ready=1 (unless flush is high).
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
- ram_index: combinational cpu_req_addr[INDEX_WIDTH-1:0] in IDLE; latched index otherwise. The RAM read therefore launches in the accept cycle.
- IDLE:
  - flush=1 -> all valid bits cleared next edge, no request accepted.
  - Otherwise, valid&&ready -> latch addr/we/wdata -> LOOKUP.
- LOOKUP: hit = valid[idx] && (tag_rdata == latched tag).
  - Load hit: cpu_resp_valid=1, cpu_resp_rdata=data_rdata -> IDLE. Total latency 1 cycle after accept.
  - Load miss -> MEM_REQ, mem_req_we=0.
  - Store hit: data_we=1, data_wdata=store data this cycle; tag and valid unchanged; -> MEM_REQ, mem_req_we=1.
  - Store miss: no RAM write -> MEM_REQ, mem_req_we=1.
- MEM_REQ: mem_req_valid=1, with addr/we/wdata stable until mem_req_ready. On the handshake edge -> MEM_WAIT.
- MEM_WAIT: wait for mem_resp_valid; no timeout.
  - Load: in the resp cycle, tag_we=1, tag_wdata=latched tag, data_we=1, data_wdata=mem_resp_rdata, valid[idx]<=1, cpu_resp_valid=1, cpu_resp_rdata=mem_resp_rdata -> IDLE.
  - Store: cpu_resp_valid=1, rdata=0 -> IDLE.
- tag_we/data_we are only ever asserted in LOOKUP (store hit) or MEM_WAIT (refill). No write and read of the same line occur in the same cycle, so RAM read-during-write semantics are irrelevant.
- mem_resp_valid outside MEM_WAIT is ignored. mem_req_ready outside MEM_REQ is ignored.
- Reset mid-transaction abandons it: no RAM write, no cpu_resp. A late mem_resp after reset is ignored.
- Back-to-back: a new request may be accepted in the cycle after cpu_resp_valid (the controller is in IDLE).
- flush takes priority over a simultaneous cpu_req_valid in IDLE. Outside IDLE, flush is ignored.

Decomposition:
- Package cache_pkg: ADDR_WIDTH/DATA_WIDTH/INDEX_WIDTH/TAG_WIDTH constants, state enum, and addr split helpers (tag_of, index_of).
- Valid-bit array as sub-module cache_valid_bits:
  - async reset clear
  - synchronous flush clear
  - single-bit set port
  - combinational read at index

Test Plan:
- Cold load addr 0x0000_0085 -> miss; mem_req addr 0x85, we=0. mem_resp 0xDEAD_BEEF -> tag_we=1 at index 0x05 with tag 0x1, cpu_resp 0xDEAD_BEEF.
- Repeat load 0x85 -> cpu_resp_valid exactly 1 cycle after accept, rdata 0xDEAD_BEEF, no mem_req.
- Load 0x0000_0105 (same index 0x05, tag 0x2) -> miss, refill overwrites line. Then load 0x85 -> miss again.
- Store 0x105 data 0x1234_5678 (hit) -> data_we in LOOKUP plus mem write. Load 0x105 -> hit 0x1234_5678. Store to an uncached address -> mem write only, no tag_we/data_we.
- Hold mem_req_ready low for 5 cycles -> mem_req_valid/addr stable throughout. Assert rst during MEM_WAIT, then pulse mem_resp_valid -> no cpu_resp, all lines invalid.
- Load hits on 0x85, then flush in IDLE together with cpu_req_valid -> request not accepted that cycle. Next load 0x85 -> miss.
